// File: rtl/gpio_pkg.sv
// Shared register map, width limit and byte-lane helper for the GPIO bank.
package gpio_pkg;

   localparam int GPIO_MAX_WIDTH = 32;

   typedef enum logic [2:0] {
      REG_OUT     = 3'd0,
      REG_IN      = 3'd1,
      REG_DIR     = 3'd2,
      REG_RISE_EN = 3'd3,
      REG_FALL_EN = 3'd4,
      REG_EVENT   = 3'd5,
      REG_SET     = 3'd6,
      REG_CLR     = 3'd7
   } gpio_reg_t;

   // Expands the four byte enables into a 32-bit bit mask.
   function automatic logic [31:0] lane_mask(input logic [3:0] mask);
      return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
   endfunction

endpackage

// File: rtl/gpio_bank_debounce.sv
// Per-channel debounce filter for the GPIO bank input path, instantiated only when GPIO_DEBOUNCE_EN is defined.
module gpio_debounce #(
   parameter int DEBOUNCE_CYCLES = 36000
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic out
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [CW-1:0] count;

   // Output follows the input only after it has differed for DEBOUNCE_CYCLES clocks in a row.
   always_ff @(posedge clk) begin
      if (reset) begin
         out   <= 1'b0;
         count <= '0;
      end else if (in == out) begin
         count <= '0;
      end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
         out   <= in;
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank with edge-detect events; define GPIO_DEBOUNCE_EN to debounce the IN register.
module gpio_bank #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 36000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      address_in,
   input  logic             sel_in,
   input  logic             read_in,
   output logic [31:0]      read_value_out,
   input  logic [3:0]       write_mask_in,
   input  logic [31:0]      write_value_in,
   output logic             ready_out,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq_out
);

   import gpio_pkg::*;

   gpio_reg_t                 reg_sel;
   logic [GPIO_MAX_WIDTH-1:0] lane_bits;
   logic [GPIO_MAX_WIDTH-1:0] wr_bits;
   logic [GPIO_MAX_WIDTH-1:0] rd_data;
   logic [WIDTH-1:0]          wr_data;
   logic [WIDTH-1:0]          wr_lanes;
   logic [WIDTH-1:0]          out_reg;
   logic [WIDTH-1:0]          dir_reg;
   logic [WIDTH-1:0]          rise_en;
   logic [WIDTH-1:0]          fall_en;
   logic [WIDTH-1:0]          event_reg;
   logic [WIDTH-1:0]          event_clr;
   logic [WIDTH-1:0]          edges;
   logic [WIDTH-1:0]          sync1;
   logic [WIDTH-1:0]          sync2;
   logic [WIDTH-1:0]          in_reg;
   logic [WIDTH-1:0]          prev_in;
   logic                      unused_ok;

   assign reg_sel   = gpio_reg_t'(address_in[4:2]);
   assign lane_bits = lane_mask(write_mask_in);
   assign wr_bits   = write_value_in & lane_bits;
   assign wr_data   = wr_bits[WIDTH-1:0];
   assign wr_lanes  = lane_bits[WIDTH-1:0];
   assign event_clr = (sel_in && reg_sel == REG_EVENT) ? wr_data : '0;
   assign edges     = (in_reg & ~prev_in & rise_en) | (~in_reg & prev_in & fall_en);
   assign unused_ok = &{1'b0, address_in, read_in, lane_bits, wr_bits};

   assign ready_out      = sel_in;
   assign gpio_out       = out_reg;
   assign gpio_oe        = dir_reg;
   assign irq_out        = |event_reg;
   assign read_value_out = rd_data;

   // Register writes, synchroniser and edge history; a fresh edge wins over a same-cycle W1C.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_reg   <= '0;
         dir_reg   <= '0;
         rise_en   <= '0;
         fall_en   <= '0;
         event_reg <= '0;
         sync1     <= '0;
         sync2     <= '0;
         prev_in   <= '0;
      end else begin
         sync1     <= gpio_in;
         sync2     <= sync1;
         prev_in   <= in_reg;
         event_reg <= (event_reg & ~event_clr) | edges;
         if (sel_in) begin
            case (reg_sel)
               REG_OUT:     out_reg <= (out_reg & ~wr_lanes) | wr_data;
               REG_DIR:     dir_reg <= (dir_reg & ~wr_lanes) | wr_data;
               REG_RISE_EN: rise_en <= (rise_en & ~wr_lanes) | wr_data;
               REG_FALL_EN: fall_en <= (fall_en & ~wr_lanes) | wr_data;
               REG_SET:     out_reg <= out_reg | wr_data;
               REG_CLR:     out_reg <= out_reg & ~wr_data;
               default:     ;
            endcase
         end
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
      gpio_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk  (clk),
         .reset(reset),
         .in   (sync2[i]),
         .out  (in_reg[i])
      );
   end
`else
   localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

   always_ff @(posedge clk) begin
      if (reset) begin
         in_reg <= '0;
      end else begin
         in_reg <= sync2;
      end
   end
`endif

   // Read mux; unimplemented upper bits and write-only registers read as zero.
   always_comb begin
      rd_data = '0;
      if (sel_in) begin
         case (reg_sel)
            REG_OUT:     rd_data[WIDTH-1:0] = out_reg;
            REG_IN:      rd_data[WIDTH-1:0] = in_reg;
            REG_DIR:     rd_data[WIDTH-1:0] = dir_reg;
            REG_RISE_EN: rd_data[WIDTH-1:0] = rise_en;
            REG_FALL_EN: rd_data[WIDTH-1:0] = fall_en;
            REG_EVENT:   rd_data[WIDTH-1:0] = event_reg;
            default:     rd_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_bank.sv
// Randomised self-checking bench for gpio_bank against a cycle-level model of the register map.
module tb_gpio_bank;

   localparam int WIDTH = 8;
   localparam int DEB   = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      address_in;
   logic             sel_in;
   logic             read_in;
   logic [31:0]      read_value_out;
   logic [3:0]       write_mask_in;
   logic [31:0]      write_value_in;
   logic             ready_out;
   logic [WIDTH-1:0] gpio_in;
   logic [WIDTH-1:0] gpio_out;
   logic [WIDTH-1:0] gpio_oe;
   logic             irq_out;

   int checkCount = 0;
   int passCount  = 0;

   logic [WIDTH-1:0] mOut, mDir, mRise, mFall, mEvt;
   logic [WIDTH-1:0] hist [4];

   gpio_bank #(
      .WIDTH(WIDTH),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .address_in    (address_in),
      .sel_in        (sel_in),
      .read_in       (read_in),
      .read_value_out(read_value_out),
      .write_mask_in (write_mask_in),
      .write_value_in(write_value_in),
      .ready_out     (ready_out),
      .gpio_in       (gpio_in),
      .gpio_out      (gpio_out),
      .gpio_oe       (gpio_oe),
      .irq_out       (irq_out)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      else
         passCount++;
   endtask

   // IN as seen by software is the pin sampled two edges earlier (hist[2]).
   function automatic logic [31:0] modelRead(input logic sel, input logic [2:0] idx);
      logic [31:0] v;
      v = 32'h0;
      if (sel) begin
         case (idx)
            3'd0: v[WIDTH-1:0] = mOut;
            3'd1: v[WIDTH-1:0] = hist[2];
            3'd2: v[WIDTH-1:0] = mDir;
            3'd3: v[WIDTH-1:0] = mRise;
            3'd4: v[WIDTH-1:0] = mFall;
            3'd5: v[WIDTH-1:0] = mEvt;
            default: v = 32'h0;
         endcase
      end
      return v;
   endfunction

   task automatic stepModel(input logic rst, input logic sel, input logic [2:0] idx,
                            input logic [3:0] mask, input logic [31:0] data, input logic [WIDTH-1:0] pin);
      logic [WIDTH-1:0] newIn, oldIn, edgeHits;
      if (rst) begin
         mOut = '0; mDir = '0; mRise = '0; mFall = '0; mEvt = '0;
         for (int i = 0; i < 4; i++) hist[i] = '0;
      end else begin
         newIn    = hist[2];
         oldIn    = hist[3];
         edgeHits = '0;
         for (int i = 0; i < WIDTH; i++) begin
            if (newIn[i] && !oldIn[i] && mRise[i]) edgeHits[i] = 1'b1;
            if (!newIn[i] && oldIn[i] && mFall[i]) edgeHits[i] = 1'b1;
         end
         for (int i = 0; i < WIDTH; i++) begin
            if (sel && mask[i/8]) begin
               case (idx)
                  3'd0: mOut[i] = data[i];
                  3'd2: mDir[i] = data[i];
                  3'd3: mRise[i] = data[i];
                  3'd4: mFall[i] = data[i];
                  3'd5: if (data[i]) mEvt[i] = 1'b0;
                  3'd6: if (data[i]) mOut[i] = 1'b1;
                  3'd7: if (data[i]) mOut[i] = 1'b0;
                  default: ;
               endcase
            end
         end
         mEvt    = mEvt | edgeHits;
         hist[3] = hist[2];
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = pin;
      end
   endtask

   // One full bus cycle: drive, check combinational read, clock, check pin outputs.
   task automatic applyStimulus(input logic rst, input logic sel, input logic [2:0] idx,
                                input logic [3:0] mask, input logic [31:0] data, input logic [WIDTH-1:0] pin);
      logic [31:0] addr;
      addr           = $urandom();
      addr[4:2]      = idx;
      reset          = rst;
      sel_in         = sel;
      read_in        = sel;
      address_in     = addr;
      write_mask_in  = mask;
      write_value_in = data;
      gpio_in        = pin;
      #1;
      checkOutput("ready", {31'b0, ready_out}, {31'b0, sel});
      if (!rst) checkOutput("read", read_value_out, modelRead(sel, idx));
      @(posedge clk);
      stepModel(rst, sel, idx, mask, data, pin);
      #1;
      reset  = 1'b0;
      sel_in = 1'b0;
      checkOutput("gpio_out", 32'(gpio_out), 32'(mOut));
      checkOutput("gpio_oe", 32'(gpio_oe), 32'(mDir));
      checkOutput("irq", {31'b0, irq_out}, {31'b0, |mEvt});
   endtask

   task automatic peek(input logic sel, input logic [2:0] idx, output logic [31:0] val);
      sel_in        = sel;
      read_in       = sel;
      address_in    = {27'b0, idx, 2'b00};
      write_mask_in = 4'h0;
      #1;
      val     = read_value_out;
      sel_in  = 1'b0;
      read_in = 1'b0;
   endtask

`ifdef GPIO_DEBOUNCE_EN
   task automatic tickRaw(input logic [WIDTH-1:0] pin);
      sel_in        = 1'b0;
      write_mask_in = 4'h0;
      gpio_in       = pin;
      @(posedge clk);
      #1;
   endtask
`endif

   initial begin
      logic [31:0] v;
      logic [WIDTH-1:0] pin;
      int seen;

      reset = 1'b1; sel_in = 1'b0; read_in = 1'b0; address_in = '0;
      write_mask_in = '0; write_value_in = '0; gpio_in = '0;

      applyStimulus(1'b1, 1'b0, 3'd0, 4'h0, 32'h0, 8'h00);
      applyStimulus(1'b1, 1'b0, 3'd0, 4'h0, 32'h0, 8'h00);
      checkOutput("reset_out", 32'(gpio_out), 32'h0);
      checkOutput("reset_irq", {31'b0, irq_out}, 32'h0);

      applyStimulus(1'b0, 1'b1, 3'd0, 4'b0001, 32'h000000A5, 8'h00);
      checkOutput("out_a5", 32'(gpio_out), 32'hA5);
      applyStimulus(1'b0, 1'b1, 3'd6, 4'b0001, 32'h0000000A, 8'h00);
      checkOutput("set_af", 32'(gpio_out), 32'hAF);
      applyStimulus(1'b0, 1'b1, 3'd7, 4'b0001, 32'h00000081, 8'h00);
      checkOutput("clr_2e", 32'(gpio_out), 32'h2E);
      peek(1'b1, 3'd0, v);
      checkOutput("read_out", v, 32'h0000002E);
      peek(1'b1, 3'd6, v);
      checkOutput("read_set", v, 32'h0);

      applyStimulus(1'b0, 1'b1, 3'd2, 4'hF, 32'hFFFFFFFF, 8'h00);
      peek(1'b1, 3'd2, v);
      checkOutput("read_dir", v, 32'h000000FF);
      checkOutput("oe_ff", 32'(gpio_oe), 32'hFF);
      peek(1'b0, 3'd1, v);
      checkOutput("read_unsel", v, 32'h0);

`ifndef GPIO_DEBOUNCE_EN
      applyStimulus(1'b0, 1'b1, 3'd3, 4'h1, 32'h01, 8'h00);
      applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 8'h01);
      peek(1'b1, 3'd1, v);
      checkOutput("in_k", v, 32'h0);
      applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 8'h01);
      peek(1'b1, 3'd1, v);
      checkOutput("in_k1", v, 32'h0);
      applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 8'h01);
      peek(1'b1, 3'd1, v);
      checkOutput("in_k2", v, 32'h1);
      peek(1'b1, 3'd5, v);
      checkOutput("evt_k2", v, 32'h0);
      applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 8'h01);
      peek(1'b1, 3'd5, v);
      checkOutput("evt_k3", v, 32'h1);
      checkOutput("irq_k3", {31'b0, irq_out}, 32'h1);

      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 8'h00);
      applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 8'h01);
      applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 8'h01);
      applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 8'h01);
      applyStimulus(1'b0, 1'b1, 3'd5, 4'h1, 32'h01, 8'h01);
      peek(1'b1, 3'd5, v);
      checkOutput("w1c_vs_edge", v, 32'h1);
      applyStimulus(1'b0, 1'b1, 3'd5, 4'h1, 32'h01, 8'h01);
      peek(1'b1, 3'd5, v);
      checkOutput("w1c_clear", v, 32'h0);

      applyStimulus(1'b0, 1'b1, 3'd3, 4'h1, 32'h03, 8'h00);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 8'h00);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 8'h03);
      peek(1'b1, 3'd5, v);
      checkOutput("evt_03", v, 32'h3);
      applyStimulus(1'b1, 1'b0, 3'd0, 4'h0, 32'h0, 8'h03);
      checkOutput("rst_irq", {31'b0, irq_out}, 32'h0);
      checkOutput("rst_out", 32'(gpio_out), 32'h0);
      checkOutput("rst_oe", 32'(gpio_oe), 32'h0);
      for (int r = 0; r < 6; r++) begin
         peek(1'b1, 3'(r), v);
         checkOutput($sformatf("rst_reg%0d", r), v, 32'h0);
      end
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 8'h03);
      peek(1'b1, 3'd5, v);
      checkOutput("no_evt_after_rst", v, 32'h0);

      pin = 8'h03;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) pin = WIDTH'($urandom());
         applyStimulus($urandom_range(0, 99) == 0, 1'($urandom()), 3'($urandom()),
                       4'($urandom()), $urandom(), pin);
      end
`else
      applyStimulus(1'b1, 1'b0, 3'd0, 4'h0, 32'h0, 8'h00);
      applyStimulus(1'b0, 1'b1, 3'd3, 4'h1, 32'h01, 8'h00);
      seen = 0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 3; i++) begin
            tickRaw(8'h01);
            peek(1'b1, 3'd1, v);
            if (v[0]) seen++;
         end
         for (int i = 0; i < 10; i++) begin
            tickRaw(8'h00);
            peek(1'b1, 3'd1, v);
            if (v[0]) seen++;
         end
      end
      checkOutput("deb_short_in", 32'(seen), 32'h0);
      peek(1'b1, 3'd5, v);
      checkOutput("deb_short_evt", v, 32'h0);
      seen = 0;
      for (int i = 0; i < 17; i++) begin
         tickRaw(i < 5 ? 8'h01 : 8'h00);
         peek(1'b1, 3'd1, v);
         if (v[0]) seen = 1;
      end
      checkOutput("deb_long_in", 32'(seen), 32'h1);
      peek(1'b1, 3'd5, v);
      checkOutput("deb_long_evt", v, 32'h1);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
